li_relay_station: RTL

Two-entry latency-insensitive relay station for long inter-block links. It sits on an li_link channel directly downstream of a wrapped pearl's output link and upstream of the next wrapper's input link. It accepts one token per cycle and registers both the forward valid/data path and the backward stop path, so no combinational path crosses the station. It also exports occupancy and a saturating downstream-stall counter for performance debug.

---
 rtl/li_relay_station_if.sv | 11 +
 rtl/li_relay_station.sv | 104 ++++++++++
 2 files changed

// File: rtl/li_relay_station_if.sv
// Latency-insensitive link: valid/data travel downstream, stop travels upstream.
interface li_link #(
  parameter int DWIDTH = 16
);
  logic              valid;
  logic              stop;
  logic [DWIDTH-1:0] data;

  modport source (output valid, output data, input stop);
  modport sink   (input valid, input data, output stop);
endinterface

// File: rtl/li_relay_station.sv
// Two-entry relay station: registers forward valid/data and backward stop so no
// combinational path crosses it; exports occupancy and a saturating stall count.
module li_relay_station #(
  parameter int DWIDTH    = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  li_link.sink                 i_link,
  li_link.source               o_link,
  output logic [1:0]           o_occupancy,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [DWIDTH-1:0]    main_q, main_d;
  logic [DWIDTH-1:0]    aux_q, aux_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept, fire;
  logic                 out_valid, in_stop;
  logic [1:0]           occ;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Handshakes use only registered stop/valid, so neither side sees a comb path.
  assign accept = i_link.valid && !in_stop;
  assign fire   = out_valid && !o_link.stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !fire)      state_d = TWO;
        else if (!accept && fire) state_d = EMPTY;
      end
      TWO:     if (fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    in_stop   = 1'b0;
    occ       = 2'd0;
    unique case (state_q)
      ONE: begin
        out_valid = 1'b1;
        occ       = 2'd1;
      end
      TWO: begin
        out_valid = 1'b1;
        in_stop   = 1'b1;
        occ       = 2'd2;
      end
      default: ;
    endcase
  end

  // Skid datapath: aux only fills when downstream stalls a token already in main.
  always_comb begin
    main_d = main_q;
    aux_d  = aux_q;
    unique case (state_q)
      EMPTY: if (accept) main_d = i_link.data;
      ONE: begin
        if (accept && fire) main_d = i_link.data;
        else if (accept)    aux_d  = i_link.data;
      end
      TWO:     if (fire) main_d = aux_q;
      default: ;
    endcase
  end

  assign cnt_d = (out_valid && o_link.stop) ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      aux_q  <= '0;
      cnt_q  <= '0;
    end else begin
      main_q <= main_d;
      aux_q  <= aux_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_link.valid = out_valid;
  assign o_link.data  = main_q;
  assign i_link.stop  = in_stop;
  assign o_occupancy  = occ;
  assign o_stall_cnt  = cnt_q;

endmodule
